// File: rtl/iter_divider_pkg.sv
// Shared constants, state encoding and helpers for the iterative divider.
package iter_divider_pkg;

   localparam int DIV_W    = 32;
   localparam int DIV_ITER = 32;
   localparam int CNT_W    = $clog2(DIV_ITER);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v);
      return v[DIV_W-1] ? -v : v;
   endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract,
// keep the difference and shift a 1 into the quotient when it does not go negative.
module iter_divider_div_step
   import iter_divider_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] dvs,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0] shifted;
   logic       fits;

   always_comb begin
      shifted = {rem, quo[W-1]};
      fits    = (shifted >= {1'b0, dvs});
      if (fits) begin
         rem_next = W'(shifted - {1'b0, dvs});
         quo_next = {quo[W-2:0], 1'b1};
      end else begin
         // The remainder stays below the divisor, so shifted[W] is zero here.
         rem_next = shifted[W-1:0];
         quo_next = {quo[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: collects a dividend/divisor pair, iterates 32 cycles
// on magnitudes, then pulses {quotient, remainder} with MIPS sign rules for one cycle.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter bit SIGNED = 1'b1,
   parameter int W      = DIV_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   s_axis_dividend_tdata,
   input  logic           s_axis_dividend_tvalid,
   output logic           s_axis_dividend_tready,
   input  logic [W-1:0]   s_axis_divisor_tdata,
   input  logic           s_axis_divisor_tvalid,
   output logic           s_axis_divisor_tready,
   output logic [2*W-1:0] m_axis_dout_tdata,
   output logic           m_axis_dout_tvalid
);

   div_state_e state, state_next;

   logic             dvd_held, dvs_held;
   logic [W-1:0]     dvd_q, dvs_q;
   logic [W-1:0]     rem, quo, dvs_mag;
   logic             q_neg, r_neg;
   logic [CNT_W-1:0] cnt;

   logic             dvd_hs, dvs_hs, start;
   logic [W-1:0]     dvd_val, dvs_val;
   logic [W-1:0]     prep_dvd, prep_dvs;
   logic             prep_q_neg, prep_r_neg;
   logic [W-1:0]     rem_next, quo_next;
   logic [W-1:0]     q_fix, r_fix;

   // Handshake: a channel transfers on a rising edge where tvalid && tready; tready is
   // high only in IDLE while that channel holds no operand, and tvalid is never dropped.
   assign s_axis_dividend_tready = (state == DIV_IDLE) && !dvd_held;
   assign s_axis_divisor_tready  = (state == DIV_IDLE) && !dvs_held;
   assign dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
   assign dvs_hs = s_axis_divisor_tvalid  && s_axis_divisor_tready;

   assign dvd_val = dvd_held ? dvd_q : s_axis_dividend_tdata;
   assign dvs_val = dvs_held ? dvs_q : s_axis_divisor_tdata;
   assign start   = (state == DIV_IDLE) && (dvd_held || dvd_hs) && (dvs_held || dvs_hs);

   always_comb begin
      prep_dvd   = dvd_val;
      prep_dvs   = dvs_val;
      prep_q_neg = 1'b0;
      prep_r_neg = 1'b0;
      // A zero divisor runs the raw dividend through unsigned iterations, which yields
      // an all-ones quotient and remainder equal to the dividend without any fix-up.
      if ((dvs_val != '0) && SIGNED) begin
         prep_dvd   = abs_val(dvd_val);
         prep_dvs   = abs_val(dvs_val);
         prep_q_neg = dvd_val[W-1] ^ dvs_val[W-1];
         prep_r_neg = dvd_val[W-1];
      end
   end

   iter_divider_div_step #(.W(W)) u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs_mag),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   assign q_fix = q_neg ? -quo_next : quo_next;
   assign r_fix = r_neg ? -rem_next : rem_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= DIV_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE: if (start) state_next = DIV_CALC;
         DIV_CALC: if (cnt == '0) state_next = DIV_DONE;
         DIV_DONE: state_next = DIV_IDLE;
         default:  state_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dvd_held           <= 1'b0;
         dvs_held           <= 1'b0;
         dvd_q              <= '0;
         dvs_q              <= '0;
         rem                <= '0;
         quo                <= '0;
         dvs_mag            <= '0;
         q_neg              <= 1'b0;
         r_neg              <= 1'b0;
         cnt                <= '0;
         m_axis_dout_tdata  <= '0;
         m_axis_dout_tvalid <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  dvd_held <= 1'b0;
                  dvs_held <= 1'b0;
                  rem      <= '0;
                  quo      <= prep_dvd;
                  dvs_mag  <= prep_dvs;
                  q_neg    <= prep_q_neg;
                  r_neg    <= prep_r_neg;
                  cnt      <= CNT_W'(DIV_ITER - 1);
               end else begin
                  if (dvd_hs) begin
                     dvd_q    <= s_axis_dividend_tdata;
                     dvd_held <= 1'b1;
                  end
                  if (dvs_hs) begin
                     dvs_q    <= s_axis_divisor_tdata;
                     dvs_held <= 1'b1;
                  end
               end
            end
            DIV_CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  m_axis_dout_tdata  <= {q_fix, r_fix};
                  m_axis_dout_tvalid <= 1'b1;
               end
            end
            DIV_DONE: m_axis_dout_tvalid <= 1'b0;
            default:  m_axis_dout_tvalid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a signed and an unsigned copy share the same operand
// stream, and each scenario task checks both copies against hand-computed results.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dvd_data = '0, dvs_data = '0;
   logic        dvd_valid = 1'b0, dvs_valid = 1'b0;

   logic        rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u;
   logic [63:0] dout_s, dout_u;
   logic        vld_s, vld_u;
   logic [3:0]  rdy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] prev_s = '0, prev_u = '0;
   int          pulse_cnt_s, pulse_cnt_u, pulse_at_s, pulse_at_u;
   logic [63:0] pulse_d_s, pulse_d_u, pre_s, pre_u;
   int          chg_s, chg_u, busy_rdy;
   logic [3:0]  last_rdy;

   assign rdy = {rdy_dvd_s, rdy_dvs_s, rdy_dvd_u, rdy_dvs_u};

   always #5 clk = ~clk;

   iter_divider #(.SIGNED(1'b1), .W(32)) dut_s (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tdata  (dvd_data),
      .s_axis_dividend_tvalid (dvd_valid),
      .s_axis_dividend_tready (rdy_dvd_s),
      .s_axis_divisor_tdata   (dvs_data),
      .s_axis_divisor_tvalid  (dvs_valid),
      .s_axis_divisor_tready  (rdy_dvs_s),
      .m_axis_dout_tdata      (dout_s),
      .m_axis_dout_tvalid     (vld_s)
   );

   iter_divider #(.SIGNED(1'b0), .W(32)) dut_u (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tdata  (dvd_data),
      .s_axis_dividend_tvalid (dvd_valid),
      .s_axis_dividend_tready (rdy_dvd_u),
      .s_axis_divisor_tdata   (dvs_data),
      .s_axis_divisor_tvalid  (dvs_valid),
      .s_axis_divisor_tready  (rdy_dvs_u),
      .m_axis_dout_tdata      (dout_u),
      .m_axis_dout_tvalid     (vld_u)
   );

   // Driver: offer both operands together; the second posedge is the capture edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
      @(posedge clk); #1;
      dvd_valid = 1'b0; dvs_valid = 1'b0;
   endtask

   // Monitor: records n cycles following a capture edge (cycle 1 = first after it).
   task automatic collect(input int n);
      logic [63:0] last_s, last_u;
      pulse_cnt_s = 0; pulse_cnt_u = 0; pulse_at_s = 0; pulse_at_u = 0;
      pulse_d_s = '0; pulse_d_u = '0; chg_s = 0; chg_u = 0; busy_rdy = 0;
      last_s = '0; last_u = '0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (vld_s) begin pulse_cnt_s++; pulse_at_s = i; pulse_d_s = dout_s; end
         if (vld_u) begin pulse_cnt_u++; pulse_at_u = i; pulse_d_u = dout_u; end
         if (i == 1) begin
            pre_s = dout_s; pre_u = dout_u;
         end else begin
            if (dout_s !== last_s) chg_s++;
            if (dout_u !== last_u) chg_u++;
         end
         last_s = dout_s; last_u = dout_u;
         if (i <= 33 && rdy !== 4'h0) busy_rdy++;
         last_rdy = rdy;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rdy, vld_s, vld_u} !== 6'b111100) begin
            $display("FAIL reset_ctrl: rdy=%b vld=%b%b, want rdy=1111 vld=00", rdy, vld_s, vld_u);
            n_fail++;
         end
         n_checks++;
         if ({dout_s, dout_u} !== 128'd0) begin
            $display("FAIL reset_dout: s=%h u=%h, want 0", dout_s, dout_u);
            n_fail++;
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_unsigned_basic();
      logic [63:0] exp_s, exp_u;
      exp_s = {32'd14, 32'd2};
      exp_u = {32'd14, 32'd2};
      launch(32'd100, 32'd7);
      collect(34);
      n_checks++;
      if ({pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u} !== {32'd1, 32'd33, 32'd1, 32'd33}) begin
         $display("FAIL basic_pulse: s cnt/at=%0d/%0d u cnt/at=%0d/%0d, want 1/33", pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u);
         n_fail++;
      end
      n_checks++;
      if ({pulse_d_s, pulse_d_u} !== {exp_s, exp_u}) begin
         $display("FAIL basic_data: s=%h u=%h, want s=%h u=%h", pulse_d_s, pulse_d_u, exp_s, exp_u);
         n_fail++;
      end
      n_checks++;
      if (busy_rdy !== 0 || last_rdy !== 4'hF) begin
         $display("FAIL basic_ready: busy cycles=%0d last=%b, want 0 and 1111", busy_rdy, last_rdy);
         n_fail++;
      end
      n_checks++;
      if ({pre_s, pre_u} !== {prev_s, prev_u} || chg_s !== 1 || chg_u !== 1) begin
         $display("FAIL basic_stable: pre s=%h u=%h chg=%0d/%0d, want pre s=%h u=%h chg=1/1", pre_s, pre_u, chg_s, chg_u, prev_s, prev_u);
         n_fail++;
      end
      prev_s = exp_s; prev_u = exp_u;
   endtask

   task automatic test_signed();
      logic [31:0] dvd_t [0:1] = '{32'hFFFF_FFF9, 32'd7};
      logic [31:0] dvs_t [0:1] = '{32'd2, 32'hFFFF_FFFE};
      logic [63:0] es_t  [0:1] = '{{32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'hFFFF_FFFD, 32'd1}};
      logic [63:0] eu_t  [0:1] = '{{32'h7FFF_FFFC, 32'd1}, {32'd0, 32'd7}};
      for (int k = 0; k < 2; k++) begin
         launch(dvd_t[k], dvs_t[k]);
         collect(34);
         n_checks++;
         if ({pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u} !== {32'd1, 32'd33, 32'd1, 32'd33}) begin
            $display("FAIL signed_pulse[%0d]: s cnt/at=%0d/%0d u cnt/at=%0d/%0d, want 1/33", k, pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u);
            n_fail++;
         end
         n_checks++;
         if (pulse_d_s !== es_t[k]) begin
            $display("FAIL signed_data_s[%0d]: got %h, want %h", k, pulse_d_s, es_t[k]);
            n_fail++;
         end
         n_checks++;
         if (pulse_d_u !== eu_t[k]) begin
            $display("FAIL signed_data_u[%0d]: got %h, want %h", k, pulse_d_u, eu_t[k]);
            n_fail++;
         end
         n_checks++;
         if (busy_rdy !== 0 || last_rdy !== 4'hF) begin
            $display("FAIL signed_ready[%0d]: busy cycles=%0d last=%b, want 0 and 1111", k, busy_rdy, last_rdy);
            n_fail++;
         end
         prev_s = es_t[k]; prev_u = eu_t[k];
      end
   endtask

   task automatic test_staggered();
      logic [63:0] exp_r;
      exp_r = {32'd8, 32'd2};
      @(posedge clk); #1;
      dvs_data = 32'd6; dvs_valid = 1'b1;
      @(posedge clk); #1;
      dvs_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rdy, vld_s, vld_u} !== 6'b101000) begin
            $display("FAIL stagger_hold[%0d]: rdy=%b vld=%b%b, want rdy=1010 vld=00", i, rdy, vld_s, vld_u);
            n_fail++;
         end
      end
      dvd_data = 32'd50; dvd_valid = 1'b1;
      @(posedge clk); #1;
      dvd_valid = 1'b0;
      collect(34);
      n_checks++;
      if ({pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u} !== {32'd1, 32'd33, 32'd1, 32'd33}) begin
         $display("FAIL stagger_pulse: s cnt/at=%0d/%0d u cnt/at=%0d/%0d, want 1/33", pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u);
         n_fail++;
      end
      n_checks++;
      if ({pulse_d_s, pulse_d_u} !== {exp_r, exp_r}) begin
         $display("FAIL stagger_data: s=%h u=%h, want %h", pulse_d_s, pulse_d_u, exp_r);
         n_fail++;
      end
      n_checks++;
      if (busy_rdy !== 0 || last_rdy !== 4'hF) begin
         $display("FAIL stagger_ready: busy cycles=%0d last=%b, want 0 and 1111", busy_rdy, last_rdy);
         n_fail++;
      end
      prev_s = exp_r; prev_u = exp_r;
   endtask

   task automatic test_boundary();
      logic [31:0] dvd_t [0:3] = '{32'h8000_0000, 32'd12345, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      logic [31:0] dvs_t [0:3] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
      logic [63:0] es_t  [0:3] = '{{32'h8000_0000, 32'd0}, {32'hFFFF_FFFF, 32'd12345},
                                   {32'hFFFF_FFFF, 32'hFFFF_FFFB}, {32'hFFFF_FFFF, 32'd0}};
      logic [63:0] eu_t  [0:3] = '{{32'd0, 32'h8000_0000}, {32'hFFFF_FFFF, 32'd12345},
                                   {32'hFFFF_FFFF, 32'hFFFF_FFFB}, {32'hFFFF_FFFF, 32'd0}};
      for (int k = 0; k < 4; k++) begin
         launch(dvd_t[k], dvs_t[k]);
         collect(34);
         n_checks++;
         if ({pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u} !== {32'd1, 32'd33, 32'd1, 32'd33}) begin
            $display("FAIL bound_pulse[%0d]: s cnt/at=%0d/%0d u cnt/at=%0d/%0d, want 1/33", k, pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u);
            n_fail++;
         end
         n_checks++;
         if (pulse_d_s !== es_t[k]) begin
            $display("FAIL bound_data_s[%0d]: got %h, want %h", k, pulse_d_s, es_t[k]);
            n_fail++;
         end
         n_checks++;
         if (pulse_d_u !== eu_t[k]) begin
            $display("FAIL bound_data_u[%0d]: got %h, want %h", k, pulse_d_u, eu_t[k]);
            n_fail++;
         end
         n_checks++;
         if ({pre_s, pre_u} !== {prev_s, prev_u} || chg_s !== ((es_t[k] != prev_s) ? 1 : 0) ||
             chg_u !== ((eu_t[k] != prev_u) ? 1 : 0)) begin
            $display("FAIL bound_stable[%0d]: pre s=%h u=%h chg=%0d/%0d, want pre s=%h u=%h", k, pre_s, pre_u, chg_s, chg_u, prev_s, prev_u);
            n_fail++;
         end
         prev_s = es_t[k]; prev_u = eu_t[k];
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] exp_r;
      exp_r = {32'd3, 32'd0};
      launch(32'd1000, 32'd10);
      for (int i = 1; i <= 10; i++) @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({rdy, vld_s, vld_u} !== 6'b111100 || {dout_s, dout_u} !== 128'd0) begin
         $display("FAIL midreset_clear: rdy=%b vld=%b%b s=%h u=%h, want rdy=1111 vld=00 dout=0", rdy, vld_s, vld_u, dout_s, dout_u);
         n_fail++;
      end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      prev_s = '0; prev_u = '0;
      collect(40);
      n_checks++;
      if (pulse_cnt_s !== 0 || pulse_cnt_u !== 0 || chg_s !== 0 || chg_u !== 0) begin
         $display("FAIL midreset_quiet: pulses=%0d/%0d changes=%0d/%0d, want all 0", pulse_cnt_s, pulse_cnt_u, chg_s, chg_u);
         n_fail++;
      end
      n_checks++;
      if (last_rdy !== 4'hF) begin
         $display("FAIL midreset_ready: rdy=%b, want 1111", last_rdy);
         n_fail++;
      end
      launch(32'd9, 32'd3);
      collect(34);
      n_checks++;
      if ({pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u} !== {32'd1, 32'd33, 32'd1, 32'd33}) begin
         $display("FAIL after_reset_pulse: s cnt/at=%0d/%0d u cnt/at=%0d/%0d, want 1/33", pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u);
         n_fail++;
      end
      n_checks++;
      if ({pulse_d_s, pulse_d_u} !== {exp_r, exp_r}) begin
         $display("FAIL after_reset_data: s=%h u=%h, want %h", pulse_d_s, pulse_d_u, exp_r);
         n_fail++;
      end
      prev_s = exp_r; prev_u = exp_r;
   endtask

   task automatic test_back_to_back();
      logic [31:0] dvd_t [0:1] = '{32'hFFFF_FF9C, 32'd1000};
      logic [31:0] dvs_t [0:1] = '{32'd7, 32'hFFFF_FFFD};
      logic [63:0] es_t  [0:1] = '{{32'hFFFF_FFF2, 32'hFFFF_FFFE}, {32'hFFFF_FEB3, 32'd1}};
      logic [63:0] eu_t  [0:1] = '{{32'h2492_4916, 32'd2}, {32'd0, 32'd1000}};
      @(posedge clk); #1;
      dvd_data = dvd_t[0]; dvs_data = dvs_t[0]; dvd_valid = 1'b1; dvs_valid = 1'b1;
      @(posedge clk); #1;
      dvd_data = dvd_t[1]; dvs_data = dvs_t[1];
      for (int k = 0; k < 2; k++) begin
         collect(34);
         n_checks++;
         if ({pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u} !== {32'd1, 32'd33, 32'd1, 32'd33}) begin
            $display("FAIL b2b_pulse[%0d]: s cnt/at=%0d/%0d u cnt/at=%0d/%0d, want 1/33", k, pulse_cnt_s, pulse_at_s, pulse_cnt_u, pulse_at_u);
            n_fail++;
         end
         n_checks++;
         if ({pulse_d_s, pulse_d_u} !== {es_t[k], eu_t[k]}) begin
            $display("FAIL b2b_data[%0d]: s=%h u=%h, want s=%h u=%h", k, pulse_d_s, pulse_d_u, es_t[k], eu_t[k]);
            n_fail++;
         end
         n_checks++;
         if (busy_rdy !== 0 || last_rdy !== 4'hF) begin
            $display("FAIL b2b_ready[%0d]: busy cycles=%0d rdy at 34=%b, want 0 and 1111", k, busy_rdy, last_rdy);
            n_fail++;
         end
         n_checks++;
         if ({pre_s, pre_u} !== {prev_s, prev_u} || chg_s !== 1 || chg_u !== 1) begin
            $display("FAIL b2b_stable[%0d]: pre s=%h u=%h chg=%0d/%0d, want pre s=%h u=%h chg=1/1", k, pre_s, pre_u, chg_s, chg_u, prev_s, prev_u);
            n_fail++;
         end
         prev_s = es_t[k]; prev_u = eu_t[k];
         if (k == 0) begin
            @(posedge clk); #1;
            dvd_valid = 1'b0; dvs_valid = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_staggered();
      test_boundary();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle radix-2 restoring divider. It is the responder end of the dividend/divisor/dout stream handshake that the execute stage drives for `div`/`divu`. The execute stage instantiates one copy with `SIGNED=1` and one with `SIGNED=0`. Each copy accepts one operand pair, iterates for 32 cycles, and returns `{quotient, remainder}` as a single-cycle valid pulse that the execute stage uses to write LO/HI.

## Interface
Parameters:
- `SIGNED`, default 1: 1 selects two's-complement division (`div`); 0 selects unsigned division (`divu`).
- `W`, default 32: operand width. Only 32 is supported; the parameter exists to keep widths symbolic.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `s_axis_dividend_tdata` in 32: dividend.
- `s_axis_dividend_tvalid` in 1: dividend offered.
- `s_axis_dividend_tready` out 1: dividend channel can accept.
- `s_axis_divisor_tdata` in 32: divisor.
- `s_axis_divisor_tvalid` in 1: divisor offered.
- `s_axis_divisor_tready` out 1: divisor channel can accept.
- `m_axis_dout_tdata` out 64: `[63:32]` quotient, `[31:0]` remainder.
- `m_axis_dout_tvalid` out 1: one-cycle result-valid pulse. There is no tready.

## Operation
- States:
  - IDLE: collecting operands.
  - CALC: iterating; a 5-bit counter counts 31 down to 0.
  - DONE: output pulse.
- Reset values:
  - state IDLE; both tready 1; dout_tvalid 0; dout_tdata 0.
  - Operand-held flags 0; counter 0.
- IDLE, operand capture:
  - Each channel is independent. A handshake (tvalid && tready) latches tdata and sets that channel's held flag.
  - A channel's tready is 0 while its held flag is set.
  - Both channels may handshake in the same cycle, or in different cycles in either order.
- IDLE -> CALC: on the edge where the second operand is captured (both flags would be set).
  - Both flags clear.
  - Both treadys go 0 and stay 0 through CALC and DONE.
- Operand preparation at entry to CALC:
  - SIGNED=1: load absolute values of the operands; record `q_neg = sign(dividend) ^ sign(divisor)` and `r_neg = sign(dividend)`.
  - SIGNED=0: load raw values; `q_neg = r_neg = 0`.
- CALC, each cycle:
  - Shift the 33-bit partial remainder left and bring in the next dividend MSB.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift 1 into the quotient; otherwise shift 0.
  - Decrement the counter. Leave CALC after the iteration at counter 0, i.e. exactly 32 iterations.
- CALC -> DONE:
  - Register `dout_tdata` = `{q_neg ? -q : q, r_neg ? -r : r}`, truncated to 32 bits each.
  - Assert `dout_tvalid` for this one cycle.
- DONE -> IDLE unconditionally:
  - `dout_tvalid` returns to 0.
  - `dout_tdata` holds its value until the next result.
  - Both treadys return to 1.
- Divide by zero (both modes): quotient 32'hFFFFFFFF and remainder = dividend. This is enforced explicitly at operand preparation and must not depend on the sign fix-up.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: quotient 32'h80000000, remainder 0. This falls out of magnitude arithmetic with truncation.
- Sign rules: the remainder takes the dividend's sign; the quotient truncates toward zero (MIPS semantics).

## Timing
- Let T be the edge capturing the last operand. CALC covers cycles T+1 .. T+32. `dout_tvalid` = 1 during cycle T+33. The earliest next accept is the edge ending cycle T+34 (IDLE).
- Result latency is therefore 33 cycles from the final operand handshake.
- tvalid offered during CALC or DONE is not accepted and must not be lost. The producer holds it, per normal stream rules, until tready.
- `reset` asserted mid-CALC or mid-DONE: immediate return to IDLE; partial result discarded; no `dout_tvalid` pulse; treadys 1 after reset deassertion.
- A single captured operand persists in IDLE indefinitely until its partner arrives.

## Structure
- `mycpu.h` gains:
  - the `DIV_W` width constant;
  - the 2-bit state encodings `DIV_IDLE`/`DIV_CALC`/`DIV_DONE`;
  - `DIV_ITER` = 32.
- There is one natural sub-module, `div_step`: combinational shift / trial-subtract / select for one iteration. It keeps the main block to the FSM, capture and sign logic.
- The execute stage replaces both vendor divider IPs with `iter_divider` instances; the port names match, so the connection changes are limited to the instantiation.

## Test plan
- Unsigned, `SIGNED=0`: 100 / 7 with both valids on the same cycle -> after 33 cycles, one pulse with dout = {32'd14, 32'd2}; both treadys 0 in between.
- Signed, `SIGNED=1`: -7 / 2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. 7 / -2 -> quotient 32'hFFFFFFFD, remainder 1.
- Staggered operands: divisor at cycle 0, dividend at cycle 5 -> divisor tready 0 from cycle 1; pulse at cycle 5+33.
- Boundary values, `SIGNED=1`:
  - 32'h80000000 / 32'hFFFFFFFF -> {32'h80000000, 0}.
  - 12345 / 0 -> {32'hFFFFFFFF, 32'd12345}.
  - Unsigned 32'hFFFFFFFF / 1 -> {32'hFFFFFFFF, 0}.
- Reset mid-operation: reset asserted at iteration 10 -> no pulse; IDLE with treadys 1; a following 9 / 3 returns {3, 0} at normal latency.
- Back-to-back: tvalids held high continuously -> the second operands are accepted exactly 34 cycles after the first; each result pulses exactly one cycle; dout is stable between pulses.
